// File: rtl/cellrv32_package.sv
// rtl/cellrv32_package.sv - vector rename types and opcode-class constants
package cellrv32_package;

  localparam int VREG_W    = 5;
  localparam int VTICKET_W = 4;
  localparam int VMAXVL_W  = 11;

  // top bit of the major-opcode class field (opcode[6:4])
  localparam int instr_opcode_msb_c = 6;

  // opcode classes of vector memory ops (LOAD-FP / STORE-FP)
  localparam logic [2:0] opcode_class_vload_c  = 3'b000;
  localparam logic [2:0] opcode_class_vstore_c = 3'b010;

  // hazard lock encodings carried with the renamed instruction
  localparam logic [1:0] lock_load_c  = 2'b11;
  localparam logic [1:0] lock_store_c = 2'b01;
  localparam logic [1:0] lock_none_c  = 2'b00;

  typedef struct packed {
    logic [6:0]          opcode;
    logic                reconfigure;
    logic [VREG_W-1:0]   dst;
    logic [VREG_W-1:0]   src1;
    logic [VREG_W-1:0]   src2;
    logic [VMAXVL_W-1:0] maxvl;
  } to_vector;

  typedef struct packed {
    logic [6:0]           opcode;
    logic                 reconfigure;
    logic [VREG_W-1:0]    dst;
    logic [VREG_W-1:0]    src1;
    logic [VREG_W-1:0]    src2;
    logic [VREG_W-1:0]    mask_src;
    logic                 dst_iszero;
    logic [1:0]           lock;
    logic [VMAXVL_W-1:0]  maxvl;
    logic [VTICKET_W-1:0] ticket;
    logic [VTICKET_W-1:0] last_ticket_src1;
    logic [VTICKET_W-1:0] last_ticket_src2;
  } remapped_v_instr;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [VREG_W-1:0]    dst;
    logic [VREG_W-1:0]    src1;
    logic [VREG_W-1:0]    src2;
    logic [VREG_W-1:0]    mask_src;
    logic [VMAXVL_W-1:0]  maxvl;
    logic [VTICKET_W-1:0] ticket;
    logic [VTICKET_W-1:0] last_ticket_src1;
    logic [VTICKET_W-1:0] last_ticket_src2;
  } memory_remapped_v_instr;

  // true for loads and stores, which also occupy the memory channel
  function automatic logic is_mem_class(input logic [2:0] opc_class);
    return (opc_class == opcode_class_vload_c) || (opc_class == opcode_class_vstore_c);
  endfunction

endpackage

// File: rtl/vrat.sv
// rtl/vrat.sv - vector register alias table with bulk clear
module vrat
  import cellrv32_package::*;
#(
  parameter int VECTOR_REGISTERS = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [VREG_W-1:0] wr_addr_i,
  input  logic [VREG_W-1:0] wr_data_i,
  input  logic [VREG_W-1:0] src1_i,
  input  logic [VREG_W-1:0] src2_i,
  input  logic [VREG_W-1:0] dst_i,
  output logic [VREG_W-1:0] src1_o,
  output logic [VREG_W-1:0] src2_o,
  output logic [VREG_W-1:0] dst_o,
  output logic              dst_mapped_o,
  output logic [VREG_W-1:0] mask_src_o
);

  logic [VREG_W-1:0]           map_q [VECTOR_REGISTERS];
  logic [VECTOR_REGISTERS-1:0] mapped_q;

  // mapped flags: cleared by reset or reconfigure, set on allocation
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clear_i) begin
      mapped_q <= '0;
    end else if (wr_en_i) begin
      mapped_q[wr_addr_i] <= 1'b1;
    end
  end

  // physical index storage; only meaningful where the mapped flag is set
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clear_i) begin
      map_q[wr_addr_i] <= wr_data_i;
    end
  end

  // unmapped registers read back as their architectural index
  assign src1_o       = mapped_q[src1_i] ? map_q[src1_i] : src1_i;
  assign src2_o       = mapped_q[src2_i] ? map_q[src2_i] : src2_i;
  assign dst_o        = map_q[dst_i];
  assign dst_mapped_o = mapped_q[dst_i];
  // v0 holds the mask operand
  assign mask_src_o   = mapped_q[0] ? map_q[0] : '0;

endmodule

// File: rtl/cellrv32_cpu_cp_vector_rename.sv
// rtl/cellrv32_cpu_cp_vector_rename.sv - vector register rename and ticket issue stage
module cellrv32_cpu_cp_vector_rename
  import cellrv32_package::*;
#(
  parameter int VECTOR_REGISTERS   = 32,
  parameter int VECTOR_LANES       = 8,
  parameter int VECTOR_TICKET_BITS = 4,
  parameter int MAX_INFLIGHT       = 8
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               valid_i,
  input  to_vector                           instr_i,
  output logic                               pop_o,
  output logic                               valid_o,
  output remapped_v_instr                    instr_o,
  input  logic                               ready_i,
  output logic                               m_valid_o,
  output memory_remapped_v_instr             m_instr_o,
  input  logic                               m_ready_i,
  input  logic                               retire_valid_i,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_o,
  output logic                               is_idle_o
);

  localparam int                   INFL_W     = $clog2(MAX_INFLIGHT + 1);
  localparam int                   LANE_SHIFT = $clog2(VECTOR_LANES);
  localparam logic [INFL_W-1:0]    MAX_INFL   = INFL_W'(MAX_INFLIGHT);
  localparam logic [VTICKET_W-1:0] TICKET_MAX = VTICKET_W'((1 << VECTOR_TICKET_BITS) - 1);
  localparam logic [VREG_W-1:0]    REG_MASK   = VREG_W'(VECTOR_REGISTERS - 1);

  logic                 exe_pend_q, mem_pend_q;
  remapped_v_instr      stage_q, renamed;
  logic [INFL_W-1:0]    inflight_q;
  logic [VTICKET_W-1:0] next_ticket_q, ticket, ticket_next;
  logic [VREG_W-1:0]    next_free_q;
  logic [VTICKET_W-1:0] last_producer_q [VECTOR_REGISTERS];

  logic [2:0]           opc_class;
  logic                 is_load, is_store, is_mem, reconf;
  logic                 stage_empty, stage_free, pop, alloc, retire;
  logic [VMAXVL_W-1:0]  hop_full;
  logic [VREG_W-1:0]    hop, dst_phys;
  logic [VREG_W-1:0]    rat_src1, rat_src2, rat_dst, rat_mask;
  logic                 dst_mapped;
  logic [VTICKET_W-1:0] lp_src1, lp_src2;

  assign opc_class = instr_i.opcode[instr_opcode_msb_c -: 3];
  assign is_load   = (opc_class == opcode_class_vload_c);
  assign is_store  = (opc_class == opcode_class_vstore_c);
  assign is_mem    = is_mem_class(opc_class);
  assign reconf    = instr_i.reconfigure;

  // a slot is free once both channels have taken it or are taking it now
  assign stage_empty = !exe_pend_q && !mem_pend_q;
  assign stage_free  = (!exe_pend_q || ready_i) && (!mem_pend_q || m_ready_i);
  assign pop = valid_i && stage_free && (inflight_q < MAX_INFL) &&
               (!reconf || (inflight_q == '0 && stage_empty));

  // a group occupies maxvl/LANES physical registers, at least one
  assign hop_full = instr_i.maxvl >> LANE_SHIFT;
  assign hop      = (hop_full == '0) ? VREG_W'(1) : hop_full[VREG_W-1:0];

  assign dst_phys = dst_mapped ? rat_dst : next_free_q;
  assign alloc    = pop && !reconf && !dst_mapped;
  assign retire   = retire_valid_i && (inflight_q != '0);

  assign ticket      = reconf ? VTICKET_W'(1) : next_ticket_q;
  assign ticket_next = (ticket == TICKET_MAX) ? VTICKET_W'(1) : ticket + VTICKET_W'(1);

  assign lp_src1 = last_producer_q[instr_i.src1];
  assign lp_src2 = last_producer_q[instr_i.src2];

  vrat #(
    .VECTOR_REGISTERS(VECTOR_REGISTERS)
  ) u_vrat (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clear_i     (pop && reconf),
    .wr_en_i     (alloc),
    .wr_addr_i   (instr_i.dst),
    .wr_data_i   (next_free_q),
    .src1_i      (instr_i.src1),
    .src2_i      (instr_i.src2),
    .dst_i       (instr_i.dst),
    .src1_o      (rat_src1),
    .src2_o      (rat_src2),
    .dst_o       (rat_dst),
    .dst_mapped_o(dst_mapped),
    .mask_src_o  (rat_mask)
  );

  // build the renamed instruction for the incoming op
  always_comb begin
    renamed                  = '0;
    renamed.opcode           = instr_i.opcode;
    renamed.reconfigure      = reconf;
    renamed.maxvl            = instr_i.maxvl;
    renamed.ticket           = ticket;
    renamed.last_ticket_src1 = (lp_src1 == '0) ? ticket : lp_src1;
    renamed.last_ticket_src2 = (lp_src2 == '0) ? ticket : lp_src2;
    renamed.mask_src         = rat_mask;
    if (reconf) begin
      renamed.dst              = instr_i.dst;
      renamed.src1             = instr_i.src1;
      renamed.src2             = instr_i.src2;
      renamed.lock             = lock_none_c;
      renamed.last_ticket_src1 = ticket;
      renamed.last_ticket_src2 = ticket;
    end else begin
      renamed.dst        = dst_phys;
      renamed.src1       = (instr_i.src1 == instr_i.dst) ? dst_phys : rat_src1;
      renamed.src2       = (instr_i.src2 == instr_i.dst) ? dst_phys : rat_src2;
      renamed.dst_iszero = is_store;
      renamed.lock       = is_load ? lock_load_c : (is_store ? lock_store_c : lock_none_c);
    end
  end

  // output stage, issue counters and allocation pointer
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      stage_q       <= '0;
      exe_pend_q    <= 1'b0;
      mem_pend_q    <= 1'b0;
      inflight_q    <= '0;
      next_ticket_q <= VTICKET_W'(1);
      next_free_q   <= '0;
    end else begin
      if (pop) begin
        stage_q       <= renamed;
        exe_pend_q    <= 1'b1;
        mem_pend_q    <= is_mem && !reconf;
        next_ticket_q <= ticket_next;
      end else begin
        if (ready_i)   exe_pend_q <= 1'b0;
        if (m_ready_i) mem_pend_q <= 1'b0;
      end
      if (pop && !retire)      inflight_q <= inflight_q + INFL_W'(1);
      else if (!pop && retire) inflight_q <= inflight_q - INFL_W'(1);
      if (pop && reconf)  next_free_q <= '0;
      else if (alloc)     next_free_q <= (next_free_q + hop) & REG_MASK;
    end
  end

  // last ticket to write each architectural register; stores write nothing
  always_ff @(posedge clk_i) begin
    if (!rstn_i || (pop && reconf)) begin
      for (int i = 0; i < VECTOR_REGISTERS; i++) last_producer_q[i] <= '0;
    end else if (pop && !is_store) begin
      last_producer_q[instr_i.dst] <= ticket;
    end
  end

  assign pop_o      = pop;
  assign valid_o    = exe_pend_q;
  assign m_valid_o  = mem_pend_q;
  assign instr_o    = stage_q;
  assign inflight_o = inflight_q;
  assign is_idle_o  = !valid_i && stage_empty && (inflight_q == '0);

  assign m_instr_o.opcode           = stage_q.opcode;
  assign m_instr_o.dst              = stage_q.dst;
  assign m_instr_o.src1             = stage_q.src1;
  assign m_instr_o.src2             = stage_q.src2;
  assign m_instr_o.mask_src         = stage_q.mask_src;
  assign m_instr_o.maxvl            = stage_q.maxvl;
  assign m_instr_o.ticket           = stage_q.ticket;
  assign m_instr_o.last_ticket_src1 = stage_q.last_ticket_src1;
  assign m_instr_o.last_ticket_src2 = stage_q.last_ticket_src2;

  // a retire with nothing in flight means the back end lost count
  assert property (@(posedge clk_i) disable iff (!rstn_i) !(retire_valid_i && inflight_q == '0));

endmodule

// File: tb/tb_cellrv32_cpu_cp_vector_rename.sv
// tb/tb_cellrv32_cpu_cp_vector_rename.sv - directed bench for the vector rename stage
module tb_cellrv32_cpu_cp_vector_rename;
  import cellrv32_package::*;

  localparam logic [6:0] OP_ALU   = 7'b1010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000111;
  localparam logic [6:0] OP_STORE = 7'b0100111;

  logic                   clk_i = 1'b0;
  logic                   rstn_i;
  logic                   valid_i;
  to_vector               instr_i;
  logic                   pop_o;
  logic                   valid_o;
  remapped_v_instr        instr_o;
  logic                   ready_i;
  logic                   m_valid_o;
  memory_remapped_v_instr m_instr_o;
  logic                   m_ready_i;
  logic                   retire_valid_i;
  logic [3:0]             inflight_o;
  logic                   is_idle_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  cellrv32_cpu_cp_vector_rename #(
    .VECTOR_REGISTERS  (32),
    .VECTOR_LANES      (8),
    .VECTOR_TICKET_BITS(4),
    .MAX_INFLIGHT      (8)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .valid_i       (valid_i),
    .instr_i       (instr_i),
    .pop_o         (pop_o),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .ready_i       (ready_i),
    .m_valid_o     (m_valid_o),
    .m_instr_o     (m_instr_o),
    .m_ready_i     (m_ready_i),
    .retire_valid_i(retire_valid_i),
    .inflight_o    (inflight_o),
    .is_idle_o     (is_idle_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk_i);
    #1;
  endtask

  function automatic to_vector mk(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [10:0] vl, input logic rc);
    to_vector t;
    t.opcode      = op;
    t.reconfigure = rc;
    t.dst         = d;
    t.src1        = s1;
    t.src2        = s2;
    t.maxvl       = vl;
    return t;
  endfunction

  task automatic do_reset;
    rstn_i = 1'b0;
    valid_i = 1'b0;
    retire_valid_i = 1'b0;
    cyc();
    cyc();
    rstn_i = 1'b1;
    #1;
  endtask

  initial begin
    ready_i = 1'b1;
    m_ready_i = 1'b1;
    instr_i = mk(OP_ALU, 0, 0, 0, 16, 0);
    do_reset();
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_m_valid", m_valid_o, 0);
    check_eq("rst_inflight", inflight_o, 0);
    check_eq("rst_idle", is_idle_o, 1);
    check_eq("rst_pop", pop_o, 0);

    // ALU sequence v2, v3, v2 with maxvl 16 / 8 lanes -> hop 2
    valid_i = 1'b1;
    instr_i = mk(OP_ALU, 2, 1, 1, 16, 0);
    #1;
    check_eq("alu1_pop", pop_o, 1);
    check_eq("alu1_valid_pre", valid_o, 0);
    cyc();
    check_eq("alu1_valid", valid_o, 1);
    check_eq("alu1_dst", instr_o.dst, 0);
    check_eq("alu1_ticket", instr_o.ticket, 1);
    check_eq("alu1_src1", instr_o.src1, 1);
    instr_i = mk(OP_ALU, 3, 2, 2, 16, 0);
    #1;
    check_eq("alu2_pop", pop_o, 1);
    cyc();
    check_eq("alu2_dst", instr_o.dst, 2);
    check_eq("alu2_ticket", instr_o.ticket, 2);
    check_eq("alu2_src1", instr_o.src1, 0);
    check_eq("alu2_lt_src1", instr_o.last_ticket_src1, 1);
    instr_i = mk(OP_ALU, 2, 3, 2, 16, 0);
    cyc();
    check_eq("alu3_dst", instr_o.dst, 0);
    check_eq("alu3_ticket", instr_o.ticket, 3);
    check_eq("alu3_src1", instr_o.src1, 2);
    check_eq("alu3_src2", instr_o.src2, 0);
    check_eq("alu3_lt_src1", instr_o.last_ticket_src1, 2);
    valid_i = 1'b0;
    retire_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    retire_valid_i = 1'b0;
    check_eq("alu_drain_inflight", inflight_o, 0);

    // load v5 then store v5 with memory channel stalled
    m_ready_i = 1'b0;
    valid_i = 1'b1;
    instr_i = mk(OP_LOAD, 5, 0, 0, 16, 0);
    cyc();
    check_eq("ld_m_valid", m_valid_o, 1);
    check_eq("ld_dst", m_instr_o.dst, 4);
    check_eq("ld_ticket", m_instr_o.ticket, 4);
    check_eq("ld_lock", instr_o.lock, 2'b11);
    instr_i = mk(OP_STORE, 5, 5, 0, 16, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("st_stall_pop", pop_o, 0);
      check_eq("st_stall_m_valid", m_valid_o, 1);
      check_eq("st_stall_m_ticket", m_instr_o.ticket, 4);
      cyc();
    end
    m_ready_i = 1'b1;
    #1;
    check_eq("st_pop", pop_o, 1);
    cyc();
    valid_i = 1'b0;
    check_eq("st_lt_src1", instr_o.last_ticket_src1, 4);
    check_eq("st_dst_iszero", instr_o.dst_iszero, 1);
    check_eq("st_lock", instr_o.lock, 2'b01);
    check_eq("st_dst", instr_o.dst, 4);
    check_eq("st_ticket", instr_o.ticket, 5);
    check_eq("st_m_valid", m_valid_o, 1);
    retire_valid_i = 1'b1;
    cyc();
    cyc();
    retire_valid_i = 1'b0;
    check_eq("ldst_inflight", inflight_o, 0);

    // throttle at MAX_INFLIGHT
    valid_i = 1'b1;
    instr_i = mk(OP_ALU, 1, 1, 1, 16, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("thr_pop", pop_o, 1);
      cyc();
    end
    check_eq("thr_inflight8", inflight_o, 8);
    check_eq("thr_pop9", pop_o, 0);
    retire_valid_i = 1'b1;
    #1;
    check_eq("thr_pop_retire", pop_o, 0);
    cyc();
    retire_valid_i = 1'b0;
    #1;
    check_eq("thr_inflight7", inflight_o, 7);
    check_eq("thr_pop_after", pop_o, 1);
    cyc();
    valid_i = 1'b0;
    check_eq("thr_inflight_back", inflight_o, 8);
    check_eq("thr_ticket", instr_o.ticket, 14);
    retire_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    retire_valid_i = 1'b0;
    check_eq("thr_drain", inflight_o, 0);

    // ticket wrap: 1..15 then back to 1
    do_reset();
    valid_i = 1'b1;
    instr_i = mk(OP_ALU, 1, 1, 1, 16, 0);
    for (int i = 0; i < 15; i++) begin
      retire_valid_i = (i > 0);
      cyc();
      check_eq("wrap_ticket", instr_o.ticket, i + 1);
    end
    retire_valid_i = 1'b1;
    cyc();
    check_eq("wrap_ticket16", instr_o.ticket, 1);
    check_eq("wrap_inflight", inflight_o, 1);
    valid_i = 1'b0;
    cyc();
    retire_valid_i = 1'b0;
    check_eq("wrap_drain", inflight_o, 0);

    // reconfigure waits for in-flight work
    valid_i = 1'b1;
    instr_i = mk(OP_ALU, 7, 0, 0, 16, 0);
    cyc();
    instr_i = mk(OP_ALU, 8, 0, 0, 16, 0);
    cyc();
    check_eq("rc_inflight2", inflight_o, 2);
    instr_i = mk(OP_ALU, 0, 0, 0, 16, 1);
    #1;
    check_eq("rc_stall0", pop_o, 0);
    retire_valid_i = 1'b1;
    cyc();
    check_eq("rc_stall1", pop_o, 0);
    cyc();
    retire_valid_i = 1'b0;
    #1;
    check_eq("rc_pop", pop_o, 1);
    cyc();
    check_eq("rc_valid", valid_o, 1);
    check_eq("rc_ticket", instr_o.ticket, 1);
    check_eq("rc_lock", instr_o.lock, 0);
    check_eq("rc_m_valid", m_valid_o, 0);
    instr_i = mk(OP_ALU, 9, 9, 9, 16, 0);
    cyc();
    check_eq("rc_next_dst", instr_o.dst, 0);
    check_eq("rc_next_ticket", instr_o.ticket, 2);
    // maxvl below lane count still advances by one register
    instr_i = mk(OP_ALU, 3, 3, 3, 4, 0);
    cyc();
    check_eq("hop_small_dst", instr_o.dst, 2);
    instr_i = mk(OP_ALU, 4, 4, 4, 16, 0);
    cyc();
    check_eq("hop_after_dst", instr_o.dst, 3);
    valid_i = 1'b0;
    retire_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    retire_valid_i = 1'b0;
    check_eq("rc_drain", inflight_o, 0);

    // reset drops a stalled staged instruction
    ready_i = 1'b0;
    valid_i = 1'b1;
    instr_i = mk(OP_ALU, 6, 0, 0, 16, 0);
    cyc();
    valid_i = 1'b0;
    check_eq("rst2_valid_pre", valid_o, 1);
    rstn_i = 1'b0;
    cyc();
    check_eq("rst2_valid", valid_o, 0);
    check_eq("rst2_inflight", inflight_o, 0);
    check_eq("rst2_idle", is_idle_o, 1);
    rstn_i = 1'b1;
    ready_i = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cellrv32_cpu_cp_vector_rename.md
CELLRV32_CPU_CP_VECTOR_RENAME -- requirements
Module: cellrv32_cpu_cp_vector_rename

Interface
REQ-001 SHALL have parameter VECTOR_REGISTERS, default 32, number of architectural/physical vregs (power of 2).
REQ-002 SHALL have parameter VECTOR_LANES, default 8, lanes per vreg group (power of 2).
REQ-003 SHALL have parameter VECTOR_TICKET_BITS, default 4, ticket width; ticket 0 reserved as "no producer".
REQ-004 SHALL have parameter MAX_INFLIGHT, default 8, maximum unretired tickets (1..2^VECTOR_TICKET_BITS-1).
REQ-005 SHALL have ports in this order:
- clk_i  in  1  clock.
- rstn_i  in  1  one clock; reset is synchronous and active-low.
- valid_i  in  1  decoded instruction present.
- instr_i  in  to_vector  decoded instruction.
- pop_o  out  1  instruction accepted this cycle.
- valid_o  out  1  execution channel valid.
- instr_o  out  remapped_v_instr  renamed instruction.
- ready_i  in  1  execution channel ready.
- m_valid_o  out  1  memory channel valid.
- m_instr_o  out  memory_remapped_v_instr  renamed memory instruction.
- m_ready_i  in  1  memory channel ready.
- retire_valid_i  in  1  one ticket retired this cycle.
- inflight_o  out  $clog2(MAX_INFLIGHT+1)  unretired ticket count.
- is_idle_o  out  1  no valid_i, output stage empty, inflight_o==0.

Function
REQ-006 SHALL register the renamed instruction in a single output stage; valid_o/m_valid_o assert the cycle after pop_o (latency 1).
REQ-007 SHALL hold two pending bits, exe_pend and mem_pend. On accept: exe_pend=1; mem_pend=1 only for load/store (opcode MSBs 000/010). Each bit clears when its valid&ready is seen. The stage is free when both bits are 0, or are being cleared this cycle.
REQ-008 SHALL assert pop_o = valid_i & stage_free & (inflight_o < MAX_INFLIGHT), with reconfigure further gated by inflight_o==0 and the stage being empty.
REQ-009 SHALL keep instr_o/m_instr_o stable while their valid is high and unaccepted.
REQ-010 SHALL assign tickets 1,2,...,2^T-1 and then wrap to 1, skipping 0. Reconfigure resets next ticket to 1.
REQ-011 SHALL compute hop = maxvl >> log2(VECTOR_LANES) combinationally from instr_i, forced to 1 if 0. There is no one-cycle lag.
REQ-012 SHALL allocate dst to next_free when dst is not already mapped, then advance next_free by hop modulo VECTOR_REGISTERS. If dst is already mapped, it SHALL reuse the mapping with no advance.
REQ-013 SHALL map a src equal to dst to the renamed dst, and map any other src through the RAT.
REQ-014 SHALL set dst_iszero=1 for stores and lock = 11 load / 01 store / 00 other. Reconfigure forces lock=00.
REQ-015 SHALL set last_ticket_srcN = last_producer[srcN], or the own ticket when that entry is 0. Non-store accepts SHALL write last_producer[dst]=ticket. Stores SHALL NOT write it.
REQ-016 SHALL update inflight_o by +1 on accept and -1 on retire_valid_i; a simultaneous accept and retire SHALL leave it unchanged. Retire at 0 SHALL be ignored, with a simulation assertion firing.
REQ-017 SHALL, on an accepted reconfigure, clear the RAT, clear last_producer, set next_free=0 and next ticket=1, and still issue the instruction on the execution channel with ticket 1.

Reset
REQ-018 SHALL, when rstn_i=0 at a clock edge, set:
- valid_o=0, m_valid_o=0, both pending bits 0;
- inflight_o=0, next ticket 1, next_free 0;
- RAT unmapped, last_producer all 0;
- pop_o=0 (combinational, follows from state);
- is_idle_o=1 while valid_i=0.
REQ-019 SHALL give reset priority over accept, retire and reconfigure. A reset mid-transfer SHALL drop the staged instruction.

Structure
REQ-020 SHALL take to_vector, remapped_v_instr, memory_remapped_v_instr and instr_opcode_msb_c from cellrv32_package; a new opcode-class constant for load/store SHALL be added there.
REQ-021 SHALL instantiate the existing vrat as its only sub-module (RAT storage, reconfigure clear, mask_src). The RAT's reset SHALL be synchronous to match.

Verification
REQ-022 SHALL cover an ALU sequence: three ALU ops with dst v2, v3, v2 and maxvl=16, LANES=8 -> dst 0, 2, 0; tickets 1, 2, 3; valid_o one cycle after each pop_o.
REQ-023 SHALL cover a load then a store to v5 with m_ready_i=0 for 3 cycles -> m_valid_o held and pop_o=0 for 3 cycles. The store SHALL then get last_ticket_src equal to the load ticket, dst_iszero=1 and lock=01.
REQ-024 SHALL cover throttling: MAX_INFLIGHT=8 with 8 accepts and no retire -> pop_o=0 on the 9th. A retire then accepts next cycle, and inflight_o stays 8.
REQ-025 SHALL cover ticket wrap: 15 accepts, each paired with retires -> the 16th ticket is 1, never 0.
REQ-026 SHALL cover reconfigure: reconfigure with inflight_o=2 -> stalls until 2 retires. It then issues with ticket 1, and the next ALU op gets dst 0.
REQ-027 SHALL cover reset: assert rstn_i=0 while valid_o=1 and ready_i=0 -> valid_o=0 next cycle, inflight_o=0, is_idle_o=1.
